// File: rtl/matmul_mem_pkg.sv
// -----------------------------------------------------------------------------
// matmul_mem_pkg
// Shared definitions for the matmul memory port and the engine that drives it.
//   src_t             : which port owns a read beat in the return pipeline
//   DEF_MEM_AW/DW     : default address/data widths, also used by the engine
//   RD_LAT_MIN/MAX    : legal range of the read latency parameter
//   rd_lat_legal()    : elaboration-time range check helper
// -----------------------------------------------------------------------------
package matmul_mem_pkg;

    localparam int DEF_MEM_AW = 16;
    localparam int DEF_MEM_DW = 32;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 8;

    typedef enum logic {
        SRC_ENG  = 1'b0,
        SRC_HOST = 1'b1
    } src_t;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/matmul_rd_pipe.sv
// -----------------------------------------------------------------------------
// matmul_rd_pipe
// Delay line for read beats: DEPTH register stages, each holding {vld, src, data}.
// DEPTH = 0 degenerates into a wire. Only the valid bits are cleared by rst;
// data/src are qualified by vld downstream and need no reset.
// Ports:
//   clk, rst          clock, synchronous active-high clear of valid bits
//   in_vld/src/data   beat entering the first stage
//   out_vld/src/data  beat leaving the last stage
//   any_vld           OR of all stage valid bits (0 when DEPTH = 0)
// -----------------------------------------------------------------------------
module matmul_rd_pipe
    import matmul_mem_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = DEF_MEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  src_t          in_src,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    output src_t          out_src,
    output logic [DW-1:0] out_data,
    output logic          any_vld
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // No storage: clock and reset are intentionally unused here.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign out_vld  = in_vld;
            assign out_src  = in_src;
            assign out_data = in_data;
            assign any_vld  = 1'b0;
        end else begin : g_stages
            logic [DEPTH-1:0] vld_q;
            logic [DEPTH-1:0] vld_d;
            src_t             src_q  [DEPTH];
            src_t             src_d  [DEPTH];
            logic [DW-1:0]    data_q [DEPTH];
            logic [DW-1:0]    data_d [DEPTH];

            // Each stage takes its input from the previous stage (stage 0 from the port).
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_link
                if (gi == 0) begin : g_head
                    assign vld_d[gi]  = in_vld;
                    assign src_d[gi]  = in_src;
                    assign data_d[gi] = in_data;
                end else begin : g_body
                    assign vld_d[gi]  = vld_q[gi-1];
                    assign src_d[gi]  = src_q[gi-1];
                    assign data_d[gi] = data_q[gi-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
                src_q  <= src_d;
                data_q <= data_d;
            end

            assign out_vld  = vld_q[DEPTH-1];
            assign out_src  = src_q[DEPTH-1];
            assign out_data = data_q[DEPTH-1];
            assign any_vld  = |vld_q;
        end
    endgenerate

endmodule

// File: rtl/matmul_mem_port.sv
// -----------------------------------------------------------------------------
// matmul_mem_port
// Single-port word memory serving the matmul engine (high priority, never
// stalled) and a host port (preload/dump, granted only on engine-idle cycles).
// Reads are registered out of the array at the accept edge and then delayed
// through RD_LAT-1 further stages so data returns exactly RD_LAT cycles later.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_req/write/addr/wdata       engine request (always accepted)
//   mem_rdata_vld/mem_rdata        engine read return (data 0 when not valid)
//   host_req/write/addr/wdata      host request, held until host_gnt
//   host_gnt                       combinational grant for the host
//   host_rdata_vld/host_rdata      host read return (data 0 when not valid)
//   oob_err                        sticky: some access addressed past the array
//   busy                           some read is still in flight
// -----------------------------------------------------------------------------
module matmul_mem_port
    import matmul_mem_pkg::*;
#(
    parameter int MEM_AW     = DEF_MEM_AW,
    parameter int MEM_DW     = DEF_MEM_DW,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    input  logic              host_req,
    input  logic              host_write,
    input  logic [MEM_AW-1:0] host_addr,
    input  logic [MEM_DW-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rdata_vld,
    output logic [MEM_DW-1:0] host_rdata,
    output logic              oob_err,
    output logic              busy
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    generate
        if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
            $error("matmul_mem_port: RD_LAT=%0d outside [%0d,%0d]", RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
        end
    endgenerate

    // ---------------- arbitration: engine first, host on idle cycles --------
    logic                  acc_vld;
    logic                  acc_write;
    src_t                  acc_src;
    logic [MEM_AW-1:0]     acc_addr;
    logic [MEM_DW-1:0]     acc_wdata;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  acc_oob;

    assign host_gnt = host_req & ~mem_req & ~rst;

    always_comb begin
        acc_vld   = ~rst & mem_req;
        acc_write = mem_write;
        acc_src   = SRC_ENG;
        acc_addr  = mem_addr;
        acc_wdata = mem_wdata;
        if (!mem_req) begin
            acc_vld   = host_gnt;
            acc_write = host_write;
            acc_src   = SRC_HOST;
            acc_addr  = host_addr;
            acc_wdata = host_wdata;
        end
    end

    assign acc_idx = acc_addr[DEPTH_LOG2-1:0];
    assign acc_oob = |acc_addr[MEM_AW-1:DEPTH_LOG2];

    // ---------------- word array with registered read -----------------------
    // The read register is loaded every cycle so the array maps onto block RAM;
    // whether the word is used is decided by the stage-0 control bits.
    logic [MEM_DW-1:0] mem_q [DEPTH];
    logic [MEM_DW-1:0] rd_word_q;

    always_ff @(posedge clk) begin
        if (acc_vld && acc_write && !acc_oob) begin
            mem_q[acc_idx] <= acc_wdata;
        end
        rd_word_q <= mem_q[acc_idx];
    end

    // ---------------- stage 0 control and sticky error ----------------------
    logic s0_vld_q, s0_vld_d;
    logic s0_oob_q;
    src_t s0_src_q;
    logic oob_err_q, oob_err_d;

    always_comb begin
        s0_vld_d  = acc_vld & ~acc_write;
        oob_err_d = oob_err_q | (acc_vld & acc_oob);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_q  <= 1'b0;
            oob_err_q <= 1'b0;
        end else begin
            s0_vld_q  <= s0_vld_d;
            oob_err_q <= oob_err_d;
        end
        s0_oob_q <= acc_oob;
        s0_src_q <= acc_src;
    end

    // Out-of-range reads return zero instead of the aliased array word.
    logic [MEM_DW-1:0] s0_data;
    assign s0_data = s0_oob_q ? '0 : rd_word_q;

    // ---------------- remaining RD_LAT-1 stages -----------------------------
    logic              pipe_vld;
    src_t              pipe_src;
    logic [MEM_DW-1:0] pipe_data;
    logic              pipe_any_vld;

    matmul_rd_pipe #(
        .DEPTH (RD_LAT - 1),
        .DW    (MEM_DW)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (s0_vld_q),
        .in_src   (s0_src_q),
        .in_data  (s0_data),
        .out_vld  (pipe_vld),
        .out_src  (pipe_src),
        .out_data (pipe_data),
        .any_vld  (pipe_any_vld)
    );

    // ---------------- output demux ------------------------------------------
    // Outputs are forced low while rst is high, so a beat due in the reset
    // cycle itself never escapes.
    logic eng_hit;
    logic host_hit;

    assign eng_hit  = ~rst & pipe_vld & (pipe_src == SRC_ENG);
    assign host_hit = ~rst & pipe_vld & (pipe_src == SRC_HOST);

    assign mem_rdata_vld  = eng_hit;
    assign mem_rdata      = eng_hit ? pipe_data : '0;
    assign host_rdata_vld = host_hit;
    assign host_rdata     = host_hit ? pipe_data : '0;
    assign oob_err        = ~rst & oob_err_q;
    assign busy           = ~rst & (s0_vld_q | pipe_any_vld);

endmodule

// File: tb/tb_matmul_mem_port.sv
// Three instances share one stimulus bus: RD_LAT = 2, 1 and 8 (index 0, 1, 2).
module tb_matmul_mem_port;
    import matmul_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_write, host_req, host_write;
    logic [15:0] mem_addr, host_addr;
    logic [31:0] mem_wdata, host_wdata;

    logic        e_vld  [3];
    logic [31:0] e_data [3];
    logic        h_vld  [3];
    logic [31:0] h_data [3];
    logic        gnt    [3];
    logic        oob    [3];
    logic        busy   [3];

    int errors = 0;
    int checks = 0;

    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        matmul_mem_port #(
            .MEM_AW(16), .MEM_DW(32), .DEPTH_LOG2(10),
            .RD_LAT((gi == 0) ? 2 : ((gi == 1) ? 1 : 8))
        ) u_dut (
            .clk(clk), .rst(rst),
            .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata_vld(e_vld[gi]), .mem_rdata(e_data[gi]),
            .host_req(host_req), .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
            .host_gnt(gnt[gi]), .host_rdata_vld(h_vld[gi]), .host_rdata(h_data[gi]),
            .oob_err(oob[gi]), .busy(busy[gi])
        );
    end

    function automatic int lat(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 8);
    endfunction

    task automatic drv_idle();
        mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        host_req = 1'b0; host_write = 1'b0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic drv_eng(input logic wr, input logic [15:0] a, input logic [31:0] d);
        mem_req = 1'b1; mem_write = wr; mem_addr = a; mem_wdata = d;
    endtask

    task automatic drv_host(input logic wr, input logic [15:0] a, input logic [31:0] d);
        host_req = 1'b1; host_write = wr; host_addr = a; host_wdata = d;
    endtask

    // All tasks start at a negedge: drive inputs, wait 1, sample, move to next negedge.
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drv_idle(); rst = 1'b1;
            drv_host(1'b0, 16'h0001, 32'h0);
            #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({e_vld[d], h_vld[d], gnt[d], oob[d], busy[d]} !== 5'b0 || e_data[d] !== 32'h0 || h_data[d] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_outputs lat=%0d cyc=%0d got vld=%b hvld=%b gnt=%b oob=%b busy=%b data=%h hdata=%h required all 0",
                             lat(d), i, e_vld[d], h_vld[d], gnt[d], oob[d], busy[d], e_data[d], h_data[d]);
                end
            end
            @(negedge clk);
        end
        rst = 1'b0; drv_idle();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({e_vld[d], h_vld[d], oob[d], busy[d]} !== 4'b0) begin
                errors++;
                $display("FAIL post_reset lat=%0d got vld=%b hvld=%b oob=%b busy=%b required 0", lat(d), e_vld[d], h_vld[d], oob[d], busy[d]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_host_preload_eng_read();
        for (int i = 0; i < 3; i++) begin
            drv_idle(); drv_host(1'b1, 16'(i), vals[i]);
            #1;
            checks++;
            if (gnt[0] !== 1'b1) begin
                errors++;
                $display("FAIL preload_gnt cyc=%0d got %b required 1", i, gnt[0]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 13; i++) begin
            drv_idle();
            if (i < 3) drv_eng(1'b0, 16'(i), 32'h0);
            #1;
            for (int d = 0; d < 3; d++) begin
                int k = i - lat(d);
                logic ev = (k >= 0 && k < 3);
                logic [31:0] ed = ev ? vals[(k >= 0 && k < 3) ? k : 0] : 32'h0;
                logic eb = (i >= 1 && i <= 2 + lat(d));
                checks++;
                if (e_vld[d] !== ev || e_data[d] !== ed || h_vld[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_read lat=%0d cyc=%0d got vld=%b data=%h hvld=%b required vld=%b data=%h hvld=0",
                             lat(d), i, e_vld[d], e_data[d], h_vld[d], ev, ed);
                end
                checks++;
                if (busy[d] !== eb) begin
                    errors++;
                    $display("FAIL b2b_busy lat=%0d cyc=%0d got %b required %b", lat(d), i, busy[d], eb);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_raw();
        for (int i = 0; i < 11; i++) begin
            drv_idle();
            if (i == 0) drv_eng(1'b1, 16'h0005, 32'h0000DEAD);
            if (i == 1) drv_eng(1'b0, 16'h0005, 32'h0);
            #1;
            for (int d = 0; d < 3; d++) begin
                logic ev = (i == 1 + lat(d));
                logic [31:0] ed = ev ? 32'h0000DEAD : 32'h0;
                checks++;
                if (e_vld[d] !== ev || e_data[d] !== ed) begin
                    errors++;
                    $display("FAIL raw lat=%0d cyc=%0d got vld=%b data=%h required vld=%b data=%h", lat(d), i, e_vld[d], e_data[d], ev, ed);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] ea [4] = '{2'd2, 2'd0, 2'd1, 2'd2};
        for (int i = 0; i < 14; i++) begin
            drv_idle();
            if (i < 4) drv_eng(1'b0, {14'h0, ea[i < 4 ? i : 0]}, 32'h0);
            if (i <= 4) drv_host(1'b0, 16'h0001, 32'h0);
            #1;
            checks++;
            if (gnt[0] !== (i == 4)) begin
                errors++;
                $display("FAIL arb_gnt cyc=%0d got %b required %b", i, gnt[0], (i == 4));
            end
            for (int d = 0; d < 3; d++) begin
                int k = i - lat(d);
                logic ev = (k >= 0 && k < 4);
                logic [31:0] ed = ev ? vals[ea[(k >= 0 && k < 4) ? k : 0]] : 32'h0;
                logic hv = (k == 4);
                logic [31:0] hd = hv ? 32'h22 : 32'h0;
                checks++;
                if (e_vld[d] !== ev || e_data[d] !== ed || h_vld[d] !== hv || h_data[d] !== hd) begin
                    errors++;
                    $display("FAIL arb_return lat=%0d cyc=%0d got vld=%b data=%h hvld=%b hdata=%h required vld=%b data=%h hvld=%b hdata=%h",
                             lat(d), i, e_vld[d], e_data[d], h_vld[d], h_data[d], ev, ed, hv, hd);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_oob();
        for (int i = 0; i < 12; i++) begin
            drv_idle();
            if (i == 0) drv_eng(1'b0, 16'h0400, 32'h0);
            if (i == 1) drv_eng(1'b1, 16'h0400, 32'h00000BAD);
            if (i == 2) drv_eng(1'b0, 16'h0000, 32'h0);
            #1;
            for (int d = 0; d < 3; d++) begin
                logic ev = (i == lat(d)) || (i == 2 + lat(d));
                logic [31:0] ed = (i == 2 + lat(d)) ? 32'h11 : 32'h0;
                checks++;
                if (e_vld[d] !== ev || e_data[d] !== ed) begin
                    errors++;
                    $display("FAIL oob_read lat=%0d cyc=%0d got vld=%b data=%h required vld=%b data=%h", lat(d), i, e_vld[d], e_data[d], ev, ed);
                end
                checks++;
                if (oob[d] !== (i >= 1)) begin
                    errors++;
                    $display("FAIL oob_err lat=%0d cyc=%0d got %b required %b", lat(d), i, oob[d], (i >= 1));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 23; i++) begin
            drv_idle();
            rst = (i == 2);
            if (i < 2) drv_eng(1'b0, 16'(i), 32'h0);
            if (i == 13) drv_eng(1'b0, 16'h0001, 32'h0);
            #1;
            for (int d = 0; d < 3; d++) begin
                int k = i - lat(d);
                logic ev = ((k == 0 || k == 1) && i < 2) || (k == 13);
                logic [31:0] ed = ev ? ((k == 0) ? 32'h11 : 32'h22) : 32'h0;
                logic eb = (i == 1) || (i >= 14 && i <= 13 + lat(d));
                logic eo = (i < 2);
                checks++;
                if (e_vld[d] !== ev || e_data[d] !== ed) begin
                    errors++;
                    $display("FAIL rst_flight_vld lat=%0d cyc=%0d got vld=%b data=%h required vld=%b data=%h", lat(d), i, e_vld[d], e_data[d], ev, ed);
                end
                checks++;
                if (busy[d] !== eb || oob[d] !== eo) begin
                    errors++;
                    $display("FAIL rst_flight_state lat=%0d cyc=%0d got busy=%b oob=%b required busy=%b oob=%b", lat(d), i, busy[d], oob[d], eb, eo);
                end
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_random_scoreboard();
        logic [31:0] mem_m [8];
        logic        hv_e [100];
        logic [31:0] hd_e [100];
        logic        hv_h [100];
        logic [31:0] hd_h [100];
        logic        oob_m, h_pend, hr, hw, mr, mw, g_exp, acc, aw, ah, ao;
        logic [15:0] ha, ma, aa;
        logic [31:0] hd, md, ad;
        oob_m = 1'b0; h_pend = 1'b0; hr = 1'b0; hw = 1'b0; ha = '0; hd = '0;
        for (int j = 0; j < 8; j++) mem_m[j] = 32'h0;
        for (int i = 0; i < 100; i++) begin
            hv_e[i] = 1'b0; hd_e[i] = 32'h0; hv_h[i] = 1'b0; hd_h[i] = 32'h0;
            if (i < 8) begin
                mr = 1'b1; mw = 1'b1; ma = 16'(i); md = $urandom; hr = 1'b0;
            end else if (i < 88) begin
                mr = ($urandom_range(0, 99) < 55);
                mw = 1'($urandom_range(0, 1));
                ma = ($urandom_range(0, 9) == 0) ? (16'h0400 | 16'($urandom_range(0, 7))) : 16'($urandom_range(0, 7));
                md = $urandom;
                if (!h_pend) begin
                    hr = 1'($urandom_range(0, 1));
                    hw = 1'($urandom_range(0, 1));
                    ha = ($urandom_range(0, 9) == 0) ? (16'h0800 | 16'($urandom_range(0, 7))) : 16'($urandom_range(0, 7));
                    hd = $urandom;
                end
            end else begin
                mr = 1'b0; mw = 1'b0; ma = '0; md = '0; hr = 1'b0;
            end
            drv_idle();
            if (mr) drv_eng(mw, ma, md);
            if (hr) drv_host(hw, ha, hd);
            #1;
            g_exp = hr & ~mr;
            for (int d = 0; d < 3; d++) begin
                int k = i - lat(d);
                logic ev = (k >= 0) ? hv_e[(k >= 0) ? k : 0] : 1'b0;
                logic [31:0] ed = (k >= 0) ? hd_e[(k >= 0) ? k : 0] : 32'h0;
                logic hv = (k >= 0) ? hv_h[(k >= 0) ? k : 0] : 1'b0;
                logic [31:0] hdd = (k >= 0) ? hd_h[(k >= 0) ? k : 0] : 32'h0;
                checks++;
                if (e_vld[d] !== ev || e_data[d] !== ed || h_vld[d] !== hv || h_data[d] !== hdd) begin
                    errors++;
                    $display("FAIL rand_return lat=%0d cyc=%0d got vld=%b data=%h hvld=%b hdata=%h required vld=%b data=%h hvld=%b hdata=%h",
                             lat(d), i, e_vld[d], e_data[d], h_vld[d], h_data[d], ev, ed, hv, hdd);
                end
                checks++;
                if (gnt[d] !== g_exp || oob[d] !== oob_m) begin
                    errors++;
                    $display("FAIL rand_ctrl lat=%0d cyc=%0d got gnt=%b oob=%b required gnt=%b oob=%b", lat(d), i, gnt[d], oob[d], g_exp, oob_m);
                end
            end
            // reference model: one accepted access, engine first
            acc = mr | hr; aw = mr ? mw : hw; aa = mr ? ma : ha; ad = mr ? md : hd; ah = ~mr;
            if (acc) begin
                ao = (aa[15:10] != 6'h0);
                if (ao) oob_m = 1'b1;
                if (aw) begin
                    if (!ao) mem_m[aa[2:0]] = ad;
                end else if (ah) begin
                    hv_h[i] = 1'b1; hd_h[i] = ao ? 32'h0 : mem_m[aa[2:0]];
                end else begin
                    hv_e[i] = 1'b1; hd_e[i] = ao ? 32'h0 : mem_m[aa[2:0]];
                end
            end
            h_pend = hr & mr;
            @(negedge clk);
        end
    endtask

    initial begin
        drv_idle();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_host_preload_eng_read();
        test_raw();
        test_arbitration();
        test_oob();
        test_reset_inflight();
        test_random_scoreboard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
